dmx14hx11: RTL
==============

DMX14HX11 -- requirements
Module: dmx14hx11

Interface
REQ-001 Parameter: WIDTH, 11, data width per lane.
REQ-002 Parameter: LANES, 4, number of output lanes; fixed at 4, and the select is LANES bits one-hot.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_data  input  WIDTH  source word.
REQ-006 Port: in_valid  input  1  source word present.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: s  input  LANES  one-hot lane select; s[0] is lane a, s[3] is lane d.
REQ-009 Port: out_a, out_b, out_c, out_d  output  WIDTH each  lane data.
REQ-010 Port: out_valid  output  LANES  per-lane word present; bit i is lane i.
REQ-011 Port: out_ready  input  LANES  per-lane sink accepts.
REQ-012 Port: sel_err  output  1  one-cycle pulse: illegal select seen with in_valid.
REQ-013 Port: err_cnt  output  8  saturating count of illegal-select cycles.

Function
REQ-014 Lane i transfer-in: in_valid && in_ready && s[i].
REQ-015 Lane i transfer-out: out_valid[i] && out_ready[i].
REQ-016 A legal select has exactly one bit set. 0000 and any multi-bit value are illegal.
REQ-017 in_ready is combinational.
- in_ready = 1 when s is legal and the selected lane is EMPTY, or FULL with out_ready high this cycle.
- in_ready = 0 otherwise.
- in_ready does not depend on in_valid.
REQ-018 Each lane is a one-entry buffer with two states: EMPTY and FULL.
- EMPTY -> FULL on transfer-in.
- FULL -> EMPTY on transfer-out without transfer-in.
- FULL -> FULL on simultaneous transfer-out and transfer-in; the new word replaces the old.
REQ-019 Latency is 1 cycle: a word accepted at edge N appears on its lane with out_valid set after edge N.
REQ-020 Lane data registers load only on transfer-in and hold otherwise. out_x is stable while out_valid[x]=1 and out_ready[x]=0.
REQ-021 Unselected lanes are unaffected by an input transfer. All lanes drain independently and concurrently.
REQ-022 Blocking on one FULL lane does not stall other lanes. Only the selected lane's state gates in_ready.
REQ-023 Illegal select with in_valid=1:
- no transfer;
- sel_err = 1 on the following cycle (registered);
- err_cnt increments by 1 and saturates at 255.
REQ-024 Illegal select with in_valid=0 has no effect; sel_err stays 0.
REQ-025 Words are never dropped or duplicated. Per-lane order equals acceptance order.

Reset
REQ-026 While reset_n=0, asynchronously:
- all lanes EMPTY;
- out_valid = 0000;
- out_a..out_d = 0;
- sel_err = 0;
- err_cnt = 0.
REQ-027 Reset asserted mid-transfer discards all buffered words. No transfer completes on the edge coinciding with reset deassertion.
REQ-028 in_ready follows REQ-017 from the post-reset state, so in_ready = 1 for a legal s right after reset.

Structure
REQ-029 Shared package dmx_pkg holds:
- WIDTH and LANES defaults;
- the lane state enumeration (EMPTY, FULL);
- an is_onehot function, reusable by the one-hot mux family.
REQ-030 Sub-module dmx_lane implements one one-entry buffer (REQ-018, REQ-020). It is instantiated LANES times; the top level holds the select decode, the error pulse and the counter.

Verification
REQ-031 Reset, then s=0001, in_data=0x7FF, in_valid=1 for one cycle, out_ready=1111 -> next cycle out_a=0x7FF and out_valid=0001; the cycle after, out_valid=0000.
REQ-032 out_ready=0000; send 0x001 to lane b (s=0010), then 0x002 to lane b -> second cycle in_ready=0; out_b holds 0x001. Then out_ready[1]=1 -> 0x002 accepted in that same cycle, and out_b=0x002 next.
REQ-033 Lane b FULL and stalled; s=0100, in_data=0x155 -> in_ready=1 and out_c=0x155 next cycle; lane b unchanged.
REQ-034 s=0011, in_valid=1 for 3 cycles -> in_ready=0 throughout; sel_err pulses on each following cycle; err_cnt=3; no out_valid change. s=0000 with in_valid=0 -> no error.
REQ-035 300 cycles of illegal select with in_valid=1 -> err_cnt reaches 255 and holds.
REQ-036 Lanes a and d FULL; assert reset_n=0 asynchronously between edges -> out_valid=0000, all outputs 0, err_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dmx_pkg.sv
// Shared definitions for the one-hot demux family: default sizes,
// lane buffer state and the one-hot select check.
package dmx_pkg;

    localparam int unsigned WIDTH_DEF = 11;
    localparam int unsigned LANES_DEF = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_e;

    // Callers zero-extend their select into 32 bits.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/dmx_lane.sv
// One-entry output buffer for a single demux lane; the data register
// loads only on transfer-in and holds otherwise.
module dmx_lane
    import dmx_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    lane_state_e state;

    assign out_valid = (state == FULL);
    // A full lane can take a new word in the same cycle it is drained.
    assign ready     = (state == EMPTY) || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            out_data <= '0;
        end else begin
            if (load) begin
                out_data <= in_data;
            end
            case (state)
                EMPTY: if (load) state <= FULL;
                FULL:  if (out_ready && !load) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/dmx14hx11.sv
// 1-to-4 demultiplexer with one-hot select, per-lane one-entry buffers,
// registered illegal-select pulse and saturating error counter.
module dmx14hx11
    import dmx_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] s,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic             sel_err,
    output logic [7:0]       err_cnt
);

    logic             legal;
    logic [LANES-1:0] lane_ready;
    logic [LANES-1:0] load;
    logic [WIDTH-1:0] lane_data [LANES];

    assign legal    = is_onehot(32'(s));
    // Only the selected lane's readiness matters, so a stalled lane never
    // blocks traffic to the others.
    assign in_ready = legal && ((s & lane_ready) != '0);
    assign load     = s & {LANES{in_valid && in_ready}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dmx_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (load[i]),
            .in_data   (in_data),
            .out_ready (out_ready[i]),
            .ready     (lane_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (lane_data[i])
        );
    end

    assign out_a = lane_data[0];
    assign out_b = lane_data[1];
    assign out_c = lane_data[2];
    assign out_d = lane_data[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            sel_err <= in_valid && !legal;
            if (in_valid && !legal && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
